// File: rtl/store_pkg.sv
// Shared store-path definitions: store_control encodings, buffered entry layout,
// drain FSM states and the per-size byte-mask / alignment helpers.
package store_pkg;

    typedef enum logic [2:0] {
        STR_NOP = 3'd0,
        STR_SB  = 3'd1,
        STR_SH  = 3'd2,
        STR_SW  = 3'd3,
        STR_SD  = 3'd4
    } store_ctrl_e;

    typedef enum logic {
        DRAIN_IDLE   = 1'b0,
        DRAIN_ACTIVE = 1'b1
    } drain_state_e;

    localparam int STORE_XLEN_MAX = 64;
    localparam int STORE_BE_MAX   = STORE_XLEN_MAX / 8;

    // Sized for the widest datapath; narrower builds leave the upper bits at zero.
    typedef struct packed {
        logic [STORE_XLEN_MAX-1:0] addr;
        logic [STORE_XLEN_MAX-1:0] data;
        logic [STORE_BE_MAX-1:0]   byte_en;
    } store_entry_t;

    function automatic logic [7:0] size_mask(input logic [2:0] ctl);
        case (ctl)
            STR_SB:  return 8'h01;
            STR_SH:  return 8'h03;
            STR_SW:  return 8'h0F;
            STR_SD:  return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    // Address low bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_bits(input logic [2:0] ctl);
        case (ctl)
            STR_SH:  return 3'b001;
            STR_SW:  return 3'b011;
            STR_SD:  return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/store_align.sv
// Combinational store front end: effective address, alignment check and
// lane-aligned write data / byte enables.
module store_align
    import store_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter bit MISALIGN_CHECK = 1'b1
) (
    input  logic [2:0]        store_control,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    input  logic [XLEN-1:0]   imm,
    output logic              op_valid,
    output logic              misaligned,
    output logic [XLEN-1:0]   addr,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN/8-1:0] byte_en
);

    localparam int BEW  = XLEN / 8;
    localparam int OFFW = $clog2(BEW);

    logic [OFFW-1:0] off;
    logic [OFFW-1:0] align_m;
    logic [OFFW-1:0] off_eff;

    always_comb begin
        addr     = rs1_val + imm;
        op_valid = (store_control == STR_SB) || (store_control == STR_SH) ||
                   (store_control == STR_SW) || ((store_control == STR_SD) && (XLEN == 64));
        align_m  = op_valid ? OFFW'(align_bits(store_control)) : '0;
        off      = addr[OFFW-1:0];
        if (MISALIGN_CHECK) begin
            misaligned = op_valid && (|(off & align_m));
            off_eff    = off;
        end else begin
            // Forced alignment: drop offset bits below the access size.
            misaligned = 1'b0;
            off_eff    = off & ~align_m;
        end
        byte_en = op_valid ? (BEW'(size_mask(store_control)) << off_eff) : '0;
        wdata   = rs2_val << {off_eff, 3'b000};
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: aligns incoming stores, queues them in a DEPTH-entry FIFO and
// drains the head to data memory over a req/ack handshake.
module store_buffer
    import store_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int DEPTH          = 4,
    parameter bit MISALIGN_CHECK = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     in_valid,
    input  logic [2:0]               store_control,
    input  logic [XLEN-1:0]          rs1_val,
    input  logic [XLEN-1:0]          rs2_val,
    input  logic [XLEN-1:0]          imm,
    output logic                     in_ready,
    output logic                     stall_pc,
    output logic                     o_misalign,
    output logic [XLEN-1:0]          o_misalign_addr,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     mem_req,
    input  logic                     mem_ack,
    output logic                     mem_rw_mode,
    output logic [XLEN-1:0]          mem_addr,
    output logic [XLEN-1:0]          mem_write_data,
    output logic [XLEN/8-1:0]        mem_byte_en
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic              op_valid;
    logic              misaligned;
    logic [XLEN-1:0]   st_addr;
    logic [XLEN-1:0]   st_data;
    logic [XLEN/8-1:0] st_be;

    store_align #(
        .XLEN           (XLEN),
        .MISALIGN_CHECK (MISALIGN_CHECK)
    ) u_align (
        .store_control (store_control),
        .rs1_val       (rs1_val),
        .rs2_val       (rs2_val),
        .imm           (imm),
        .op_valid      (op_valid),
        .misaligned    (misaligned),
        .addr          (st_addr),
        .wdata         (st_data),
        .byte_en       (st_be)
    );

    store_entry_t  fifo_mem [DEPTH];
    store_entry_t  wr_entry;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    drain_state_e  state_reg;
    logic          misalign_reg;
    logic [XLEN-1:0] misalign_addr_reg;

    logic push;
    logic pop;
    logic misalign_hit;

    always_comb begin
        in_ready     = (count_reg != CW'(DEPTH));
        misalign_hit = in_valid && op_valid && misaligned;
        push         = in_valid && op_valid && !misaligned && in_ready;
        stall_pc     = in_valid && op_valid && !misaligned && !in_ready;
        pop          = mem_req && mem_ack;

        wr_entry         = '0;
        wr_entry.addr    = STORE_XLEN_MAX'(st_addr);
        wr_entry.data    = STORE_XLEN_MAX'(st_data);
        wr_entry.byte_en = STORE_BE_MAX'(st_be);
    end

    // Storage has no reset: validity is carried entirely by count_reg.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= wr_entry;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            count_reg         <= '0;
            state_reg         <= DRAIN_IDLE;
            misalign_reg      <= 1'b0;
            misalign_addr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            case (state_reg)
                DRAIN_IDLE:   if (push) state_reg <= DRAIN_ACTIVE;
                DRAIN_ACTIVE: if (pop && !push && (count_reg == CW'(1))) state_reg <= DRAIN_IDLE;
                default:      state_reg <= DRAIN_IDLE;
            endcase
            misalign_reg <= misalign_hit;
            if (misalign_hit) misalign_addr_reg <= st_addr;
        end
    end

    always_comb begin
        o_empty         = (count_reg == '0);
        o_count         = count_reg;
        o_misalign      = misalign_reg;
        o_misalign_addr = misalign_addr_reg;
        mem_req         = (state_reg == DRAIN_ACTIVE);
        mem_rw_mode     = !mem_req;
        mem_addr        = mem_req ? fifo_mem[rd_ptr_reg].addr[XLEN-1:0] : '0;
        mem_write_data  = mem_req ? fifo_mem[rd_ptr_reg].data[XLEN-1:0] : '0;
        mem_byte_en     = mem_req ? fifo_mem[rd_ptr_reg].byte_en[XLEN/8-1:0] : '0;
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a 32-bit instance with a drain
// scoreboard and a 64-bit forced-alignment instance with directed checks.
module tb_store_buffer;

    localparam logic [2:0] C_NOP = 3'd0;
    localparam logic [2:0] C_SB  = 3'd1;
    localparam logic [2:0] C_SH  = 3'd2;
    localparam logic [2:0] C_SW  = 3'd3;
    localparam logic [2:0] C_SD  = 3'd4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [2:0]  store_control;
    logic [31:0] rs1_val, rs2_val, imm;
    logic        in_ready, stall_pc, o_misalign, o_empty;
    logic [31:0] o_misalign_addr;
    logic [2:0]  o_count;
    logic        mem_req, mem_ack, mem_rw_mode;
    logic [31:0] mem_addr, mem_write_data;
    logic [3:0]  mem_byte_en;

    logic        v64;
    logic [2:0]  ctl64;
    logic [63:0] a64, d64, i64;
    logic        rdy64, stall64, mis64, empty64;
    logic [63:0] misaddr64;
    logic [2:0]  cnt64;
    logic        req64, ack64, rw64;
    logic [63:0] addr64, data64;
    logic [7:0]  be64;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    exp_t sb[$];

    store_buffer #(.XLEN(32), .DEPTH(4), .MISALIGN_CHECK(1'b1)) u_dut (
        .i_clk(clk), .i_rst(rst), .in_valid(in_valid), .store_control(store_control),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
        .in_ready(in_ready), .stall_pc(stall_pc), .o_misalign(o_misalign),
        .o_misalign_addr(o_misalign_addr), .o_empty(o_empty), .o_count(o_count),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_rw_mode(mem_rw_mode),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_byte_en(mem_byte_en)
    );

    store_buffer #(.XLEN(64), .DEPTH(4), .MISALIGN_CHECK(1'b0)) u_dut64 (
        .i_clk(clk), .i_rst(rst), .in_valid(v64), .store_control(ctl64),
        .rs1_val(a64), .rs2_val(d64), .imm(i64),
        .in_ready(rdy64), .stall_pc(stall64), .o_misalign(mis64),
        .o_misalign_addr(misaddr64), .o_empty(empty64), .o_count(cnt64),
        .mem_req(req64), .mem_ack(ack64), .mem_rw_mode(rw64),
        .mem_addr(addr64), .mem_write_data(data64), .mem_byte_en(be64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model32(input logic [2:0] ctl, input logic [31:0] a,
                                     input logic [31:0] i, input logic [31:0] d);
        exp_t e;
        logic [1:0] off;
        logic [3:0] m;
        e.addr = a + i;
        off    = e.addr[1:0];
        case (ctl)
            C_SB:    m = 4'b0001;
            C_SH:    m = 4'b0011;
            default: m = 4'b1111;
        endcase
        e.be   = m << off;
        e.data = d << (8 * off);
        return e;
    endfunction

    // Every presented head must match the oldest expected store.
    always @(negedge clk) begin
        if (!rst && mem_req) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                check("head_addr", 64'(mem_addr), 64'(sb[0].addr));
                check("head_data", 64'(mem_write_data), 64'(sb[0].data));
                check("head_be", 64'(mem_byte_en), 64'(sb[0].be));
                check("head_rw", 64'(mem_rw_mode), 64'd0);
                if (mem_ack) begin
                    $display("retire addr=%h data=%h be=%b", mem_addr, mem_write_data, mem_byte_en);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic do_store(input logic [2:0] ctl, input logic [31:0] a,
                            input logic [31:0] i, input logic [31:0] d);
        in_valid = 1'b1; store_control = ctl; rs1_val = a; imm = i; rs2_val = d;
        @(posedge clk); #1;
        in_valid = 1'b0; store_control = C_NOP;
    endtask

    task automatic push_store(input logic [2:0] ctl, input logic [31:0] a,
                              input logic [31:0] i, input logic [31:0] d);
        sb.push_back(model32(ctl, a, i, d));
        do_store(ctl, a, i, d);
    endtask

    task automatic drain_all();
        int c = 0;
        @(posedge clk); #1;
        mem_ack = 1'b1;
        while (o_empty !== 1'b1 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        mem_ack = 1'b0;
        check("drain_done", 64'(o_empty), 64'd1);
        check("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic store64(input logic [2:0] ctl, input logic [63:0] a,
                           input logic [63:0] i, input logic [63:0] d);
        v64 = 1'b1; ctl64 = ctl; a64 = a; i64 = i; d64 = d;
        @(posedge clk); #1;
        v64 = 1'b0; ctl64 = C_NOP;
    endtask

    task automatic ack64_pulse();
        ack64 = 1'b1;
        @(posedge clk); #1;
        ack64 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; store_control = C_NOP;
        rs1_val = '0; rs2_val = '0; imm = '0; mem_ack = 1'b0;
        v64 = 1'b0; ctl64 = C_NOP; a64 = '0; i64 = '0; d64 = '0; ack64 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_stall", 64'(stall_pc), 64'd0);
        check("rst_empty", 64'(o_empty), 64'd1);
        check("rst_count", 64'(o_count), 64'd0);
        check("rst_req", 64'(mem_req), 64'd0);
        check("rst_rw", 64'(mem_rw_mode), 64'd1);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_data", 64'(mem_write_data), 64'd0);
        check("rst_be", 64'(mem_byte_en), 64'd0);
        check("rst_mis", 64'(o_misalign), 64'd0);
        check("rst_mis_addr", 64'(o_misalign_addr), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // SB at byte offset 3
        push_store(C_SB, 32'h1000, 32'd3, 32'h0000_00AB);
        @(negedge clk);
        check("sb_req", 64'(mem_req), 64'd1);
        check("sb_addr", 64'(mem_addr), 64'h1003);
        check("sb_data", 64'(mem_write_data), 64'hAB00_0000);
        check("sb_be", 64'(mem_byte_en), 64'b1000);
        check("sb_rw", 64'(mem_rw_mode), 64'd0);
        @(posedge clk); #1;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("sb_empty_after", 64'(o_empty), 64'd1);
        check("sb_idle_rw", 64'(mem_rw_mode), 64'd1);

        // SH then a misaligned SW
        push_store(C_SH, 32'h2000, 32'd2, 32'h0000_1234);
        @(negedge clk);
        check("sh_data", 64'(mem_write_data), 64'h1234_0000);
        check("sh_be", 64'(mem_byte_en), 64'b1100);
        in_valid = 1'b1; store_control = C_SW; rs1_val = 32'h2000; imm = 32'd2; rs2_val = 32'hCAFE_F00D;
        #1;
        check("mis_no_stall", 64'(stall_pc), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; store_control = C_NOP;
        @(negedge clk);
        check("mis_pulse", 64'(o_misalign), 64'd1);
        check("mis_addr", 64'(o_misalign_addr), 64'h2002);
        check("mis_count", 64'(o_count), 64'd1);
        @(negedge clk);
        check("mis_pulse_end", 64'(o_misalign), 64'd0);
        check("mis_addr_hold", 64'(o_misalign_addr), 64'h2002);
        drain_all();

        // Fill to DEPTH, stall the fifth store, free one slot
        for (int k = 0; k < 4; k++) begin
            push_store(C_SW, 32'h100 + 32'(4 * k), 32'd0, 32'hA0 + 32'(k));
        end
        @(negedge clk);
        check("full_count", 64'(o_count), 64'd4);
        check("full_ready", 64'(in_ready), 64'd0);
        sb.push_back(model32(C_SW, 32'h110, 32'd0, 32'hA4));
        in_valid = 1'b1; store_control = C_SW; rs1_val = 32'h110; imm = 32'd0; rs2_val = 32'hA4;
        #1;
        check("full_stall", 64'(stall_pc), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("full_hold_count", 64'(o_count), 64'd4);
        check("full_hold_stall", 64'(stall_pc), 64'd1);
        @(posedge clk); #1;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("free_count", 64'(o_count), 64'd3);
        check("free_ready", 64'(in_ready), 64'd1);
        check("free_stall", 64'(stall_pc), 64'd0);
        check("free_head", 64'(mem_addr), 64'h104);
        @(posedge clk); #1;
        in_valid = 1'b0; store_control = C_NOP;
        @(negedge clk);
        check("refill_count", 64'(o_count), 64'd4);
        drain_all();

        // Streaming with ack held high
        mem_ack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            sb.push_back(model32(C_SW, 32'h200 + 32'(4 * k), 32'd0, 32'h5500 + 32'(k)));
            in_valid = 1'b1; store_control = C_SW; rs1_val = 32'h200 + 32'(4 * k);
            imm = 32'd0; rs2_val = 32'h5500 + 32'(k);
            @(negedge clk);
            if (k > 0) begin
                check("stream_count", 64'(o_count), 64'd1);
                check("stream_req", 64'(mem_req), 64'd1);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; store_control = C_NOP;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("stream_empty", 64'(o_empty), 64'd1);
        check("stream_sb", 64'(sb.size()), 64'd0);

        // Reset with entries in flight
        for (int k = 0; k < 3; k++) begin
            push_store(C_SW, 32'h400 + 32'(4 * k), 32'd0, 32'h77 + 32'(k));
        end
        @(negedge clk);
        check("pre_rst_count", 64'(o_count), 64'd3);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        @(negedge clk);
        check("rst2_req", 64'(mem_req), 64'd0);
        check("rst2_count", 64'(o_count), 64'd0);
        check("rst2_addr", 64'(mem_addr), 64'd0);
        check("rst2_data", 64'(mem_write_data), 64'd0);
        check("rst2_be", 64'(mem_byte_en), 64'd0);
        check("rst2_rw", 64'(mem_rw_mode), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_count", 64'(o_count), 64'd0);
        push_store(C_SB, 32'h3000, 32'd1, 32'h77);
        @(negedge clk);
        check("post_rst_addr", 64'(mem_addr), 64'h3001);
        check("post_rst_be", 64'(mem_byte_en), 64'b0010);
        check("post_rst_data", 64'(mem_write_data), 64'h0000_7700);
        drain_all();

        // 64-bit instance, forced alignment
        store64(C_SD, 64'h8, 64'h0, 64'h1122_3344_5566_7788);
        store64(C_SB, 64'h10, 64'h5, 64'h5A);
        store64(C_SW, 64'h10, 64'h6, 64'hDEAD_BEEF);
        @(negedge clk);
        check("x64_count", 64'(cnt64), 64'd3);
        check("x64_no_mis", 64'(mis64), 64'd0);
        check("x64_sd_addr", addr64, 64'h8);
        check("x64_sd_data", data64, 64'h1122_3344_5566_7788);
        check("x64_sd_be", 64'(be64), 64'hFF);
        @(posedge clk); #1;
        ack64_pulse();
        @(negedge clk);
        check("x64_sb_addr", addr64, 64'h15);
        check("x64_sb_be", 64'(be64), 64'b0010_0000);
        check("x64_sb_data", data64, 64'h0000_5A00_0000_0000);
        @(posedge clk); #1;
        ack64_pulse();
        @(negedge clk);
        check("x64_sw_addr", addr64, 64'h16);
        check("x64_sw_be", 64'(be64), 64'hF0);
        check("x64_sw_data", data64, 64'hDEAD_BEEF_0000_0000);
        @(posedge clk); #1;
        ack64_pulse();
        @(negedge clk);
        check("x64_empty", 64'(empty64), 64'd1);
        check("x64_idle_rw", 64'(rw64), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
